hs_rx_buffer: RTL and testbench

Peripheral-side receive stage for the CPU→peripheral send/ack four-phase handshake.
- Synchronises the asynchronous `send` strobe into the `clk1` domain.
- Captures `dataInput` into a small FIFO and returns `ack`.
- Holds off `ack` while the FIFO is full, which back-pressures the CPU.
- Downstream peripheral logic drains words through a valid/read-enable interface.

---
 rtl/hs_rx_buffer_pkg.sv | 14 +
 rtl/hs_sync.sv | 24 ++
 rtl/hs_rx_buffer.sv | 135 +++++++++++++
 tb/tb_hs_rx_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hs_rx_buffer_pkg.sv
// rtl/hs_rx_buffer_pkg.sv - shared state encoding and handshake defaults
package hs_rx_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_ACK        = 2'd2
    } state_t;

    // Defaults shared with the CPU-side sender
    localparam int DEF_DATA_W = 2;
    localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/hs_sync.sv
// rtl/hs_sync.sv - parameterised flop chain for an asynchronous single-bit input
module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the metastability-settling chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hs_rx_buffer.sv
// rtl/hs_rx_buffer.sv - send/ack receive stage with capture FIFO and read port
module hs_rx_buffer
    import hs_rx_buffer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk1,
    input  logic                     rst1,
    input  logic                     send,
    input  logic [DATA_W-1:0]        dataInput,
    output logic                     ack,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               rx_total
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              send_s;
    state_t            state_q;
    logic              ack_q;
    logic [7:0]        rx_total_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              full;
    logic              do_write;
    logic              do_pop;

    hs_sync #(
        .STAGES (SYNC_STAGES)
    ) u_send_sync (
        .clk_i  (clk1),
        .rst_ni (rst1),
        .d_i    (send),
        .q_o    (send_s)
    );

    // Full is judged on the registered occupancy, so a pop frees space one edge later
    assign full     = (count_q == CNT_W'(DEPTH));
    // Only a live request may capture; a sender that aborts in WAIT_SPACE never writes
    assign do_write = send_s && !full &&
                      ((state_q == ST_IDLE) || (state_q == ST_WAIT_SPACE));
    assign do_pop   = rd_en && (count_q != '0);

    // Occupancy next-state: simultaneous write and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({do_write, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Handshake FSM with registered ack and accepted-word counter
    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            rx_total_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (send_s) begin
                        if (!full) begin
                            state_q    <= ST_ACK;
                            ack_q      <= 1'b1;
                            rx_total_q <= rx_total_q + 8'd1;
                        end else begin
                            state_q <= ST_WAIT_SPACE;
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    if (!send_s) begin
                        state_q <= ST_IDLE;
                    end else if (!full) begin
                        state_q    <= ST_ACK;
                        ack_q      <= 1'b1;
                        rx_total_q <= rx_total_q + 8'd1;
                    end
                end
                ST_ACK: begin
                    if (!send_s) begin
                        state_q <= ST_IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed while count is non-zero
    always_ff @(posedge clk1) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= dataInput;
        end
    end

    assign ack      = ack_q;
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign count    = count_q;
    assign rx_total = rx_total_q;

endmodule

// File: tb/tb_hs_rx_buffer.sv
// tb/tb_hs_rx_buffer.sv - self-checking bench for hs_rx_buffer
module tb_hs_rx_buffer;

    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;

    logic              clk1 = 1'b0;
    logic              rst1 = 1'b0;
    logic              send = 1'b0;
    logic [DATA_W-1:0] dataInput = '0;
    logic              ack;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [2:0]        count;
    logic [7:0]        rx_total;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_q[$];
    int                model_total = 0;

    hs_rx_buffer #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk1      (clk1),
        .rst1      (rst1),
        .send      (send),
        .dataInput (dataInput),
        .ack       (ack),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .rx_total  (rx_total)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(model_q.size()));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
        check({tag, ".rx_total"}, 32'(rx_total), 32'(model_total % 256));
        if (model_q.size() != 0) begin
            check({tag, ".rd_data"}, 32'(rd_data), 32'(model_q[0]));
        end
    endtask

    // Raise send, expect ack exactly on the 2nd edge after the sampling edge
    task automatic raise_send(input logic [DATA_W-1:0] d, input string tag);
        dataInput = d;
        send = 1'b1;
        tick();
        tick();
        check({tag, ".ack_early"}, 32'(ack), 32'd0);
        tick();
        check({tag, ".ack_rise"}, 32'(ack), 32'd1);
        model_q.push_back(d);
        model_total++;
        check_state(tag);
    endtask

    task automatic drop_send(input string tag);
        send = 1'b0;
        tick();
        tick();
        check({tag, ".ack_hold"}, 32'(ack), 32'd1);
        tick();
        check({tag, ".ack_fall"}, 32'(ack), 32'd0);
    endtask

    task automatic handshake(input logic [DATA_W-1:0] d, input string tag);
        raise_send(d, tag);
        drop_send(tag);
        check_state({tag, ".post"});
    endtask

    task automatic pop(input string tag);
        check({tag, ".head"}, 32'(rd_data), 32'(model_q[0]));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        void'(model_q.pop_front());
        check_state(tag);
    endtask

    initial begin
        // Reset held across three edges
        tick();
        tick();
        tick();
        check("rst.ack", 32'(ack), 32'd0);
        check("rst.rd_valid", 32'(rd_valid), 32'd0);
        check("rst.count", 32'(count), 32'd0);
        check("rst.rx_total", 32'(rx_total), 32'd0);
        rst1 = 1'b1;
        tick();

        // Single transfer
        handshake(2'b10, "single");
        pop("single.pop");

        // Fill, then back-pressure the fifth request
        handshake(2'b01, "fill0");
        handshake(2'b10, "fill1");
        handshake(2'b11, "fill2");
        handshake(2'b00, "fill3");
        check("fill.count", 32'(count), 32'd4);
        dataInput = 2'b01;
        send = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("bp.ack_wait", 32'(ack), 32'd0);
        check("bp.count_full", 32'(count), 32'd4);
        check("bp.head", 32'(rd_data), 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        void'(model_q.pop_front());
        check("bp.ack_after_pop", 32'(ack), 32'd0);
        check("bp.count_after_pop", 32'(count), 32'd3);
        tick();
        check("bp.ack_capture", 32'(ack), 32'd1);
        model_q.push_back(2'b01);
        model_total++;
        check_state("bp.capture");
        drop_send("bp");
        while (model_q.size() != 0) pop("bp.drain");

        // Pop and capture on the same edge at count=2
        handshake(2'b11, "sim0");
        handshake(2'b00, "sim1");
        dataInput = 2'b10;
        send = 1'b1;
        tick();
        tick();
        check("sim.head", 32'(rd_data), 32'd3);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("sim.ack", 32'(ack), 32'd1);
        void'(model_q.pop_front());
        model_q.push_back(2'b10);
        model_total++;
        check_state("sim");
        drop_send("sim");
        while (model_q.size() != 0) pop("sim.drain");

        // Reads from an empty FIFO are ignored
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd_en = 1'b0;
        check_state("empty_rd");
        handshake(2'b01, "after_empty");
        pop("after_empty.pop");

        // Randomised traffic against the queue model
        for (int i = 0; i < 40; i++) begin
            if (model_q.size() == 0 ||
                (model_q.size() < DEPTH && $urandom_range(0, 1) == 0)) begin
                handshake(DATA_W'($urandom_range(0, 3)), "rand.hs");
            end else begin
                pop("rand.pop");
            end
        end
        while (model_q.size() != 0) pop("rand.drain");

        // Reset while ack=1 and send=1, then recapture after release
        raise_send(2'b11, "mid");
        #2;
        rst1 = 1'b0;
        #1;
        check("mid.rst_ack", 32'(ack), 32'd0);
        check("mid.rst_count", 32'(count), 32'd0);
        check("mid.rst_valid", 32'(rd_valid), 32'd0);
        check("mid.rst_total", 32'(rx_total), 32'd0);
        model_q.delete();
        model_total = 0;
        tick();
        rst1 = 1'b1;
        tick();
        tick();
        check("recap.ack_early", 32'(ack), 32'd0);
        tick();
        check("recap.ack", 32'(ack), 32'd1);
        model_q.push_back(2'b11);
        model_total++;
        check_state("recap");
        drop_send("recap");
        pop("recap.pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
